// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the five-stage core: forwarding, load-use,
// branch flush, multi-cycle mul/div occupancy and data-memory wait states.
module hazard_ctrl_unit #(
  parameter int RA_W   = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  rs1D,
  input  logic [RA_W-1:0]  rs2D,
  input  logic [RA_W-1:0]  rs1E,
  input  logic [RA_W-1:0]  rs2E,
  input  logic [RA_W-1:0]  rdE,
  input  logic [RA_W-1:0]  rdM,
  input  logic [RA_W-1:0]  rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             resultSrcE0,
  input  logic [1:0]       pcSrcE,
  input  logic             mdStartE,
  input  logic             memReqM,
  input  logic             memReadyM,
  input  logic             clrStats,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit MULTI = (MD_LAT > 1);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

  md_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_stall;
  logic w_md_stall;
  logic w_stall_e;
  logic w_branch;
  logic w_load_use;
  logic w_lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (rs == '0)                   return 2'b00;
    else if (rs == rdM && regWriteM) return 2'b10;
    else if (rs == rdW && regWriteW) return 2'b01;
    else                             return 2'b00;
  endfunction

  assign forwardAE = fwd_sel(rs1E);
  assign forwardBE = fwd_sel(rs2E);

  // Mul/div stalls Execute from its first cycle; the release cycle (cnt==1) lets it advance.
  assign w_mem_stall = memReqM && !memReadyM;
  assign w_md_stall  = ((r_state == IDLE) && mdStartE && MULTI) ||
                       ((r_state == MD_BUSY) && (r_cnt > CNT_ONE));
  assign w_stall_e   = w_mem_stall || w_md_stall;
  assign w_branch    = (pcSrcE != 2'b00) && !w_stall_e;
  assign w_load_use  = resultSrcE0 && (rdE != '0) && ((rs1D == rdE) || (rs2D == rdE));
  assign w_lw_stall  = w_load_use && !w_stall_e && !w_branch;

  assign stallF = w_stall_e || w_lw_stall;
  assign stallD = w_stall_e || w_lw_stall;
  assign stallE = w_stall_e;
  assign stallM = w_mem_stall;
  assign flushW = w_mem_stall;
  assign flushM = w_md_stall && !w_mem_stall;
  assign flushD = w_branch;
  assign flushE = w_branch || w_lw_stall;
  assign mdBusy = (r_state == MD_BUSY);
  assign stallCount = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mdStartE && MULTI && !w_mem_stall) begin
            r_state <= MD_BUSY;
            r_cnt   <= CNT_LOAD;
          end
        end
        MD_BUSY: begin
          if (!w_mem_stall) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_stall_cnt <= '0;
    else if (clrStats)               r_stall_cnt <= '0;
    else if (stallF && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one instance at MD_LAT=4/CNT_W=4 and
// one at MD_LAT=1 sharing the same stimulus.
module tb_hazard_ctrl_unit;

  localparam int RA_W = 5;
  localparam int CW4  = 4;

  logic clk, rst_n;
  logic [RA_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteM, regWriteW, resultSrcE0, mdStartE, memReqM, memReadyM, clrStats;
  logic [1:0] pcSrcE;

  logic [1:0] forwardAE, forwardBE;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mdBusy;
  logic [CW4-1:0] stallCount;

  logic [1:0] forwardAE_1, forwardBE_1;
  logic stallF_1, stallD_1, stallE_1, stallM_1, flushD_1, flushE_1, flushM_1, flushW_1, mdBusy_1;
  logic [15:0] stallCount_1;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl_unit #(.RA_W(RA_W), .MD_LAT(4), .CNT_W(CW4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .resultSrcE0(resultSrcE0),
    .pcSrcE(pcSrcE), .mdStartE(mdStartE), .memReqM(memReqM), .memReadyM(memReadyM),
    .clrStats(clrStats),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .mdBusy(mdBusy), .stallCount(stallCount)
  );

  hazard_ctrl_unit #(.RA_W(RA_W), .MD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .resultSrcE0(resultSrcE0),
    .pcSrcE(pcSrcE), .mdStartE(mdStartE), .memReqM(memReqM), .memReadyM(memReadyM),
    .clrStats(clrStats),
    .forwardAE(forwardAE_1), .forwardBE(forwardBE_1),
    .stallF(stallF_1), .stallD(stallD_1), .stallE(stallE_1), .stallM(stallM_1),
    .flushD(flushD_1), .flushE(flushE_1), .flushM(flushM_1), .flushW(flushW_1),
    .mdBusy(mdBusy_1), .stallCount(stallCount_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    regWriteM = 0; regWriteW = 0; resultSrcE0 = 0;
    pcSrcE = 2'b00; mdStartE = 0; memReqM = 0; memReadyM = 0; clrStats = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("rst_cnt", 32'(stallCount), 0);
    chk("rst_busy", 32'(mdBusy), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_stallF", 32'(stallF), 0);
    chk("idle_fwdA", 32'(forwardAE), 0);

    // forwarding priority
    rs1E = 5; rdM = 5; rdW = 5; regWriteM = 1; regWriteW = 1; #1;
    chk("fwdA_M", 32'(forwardAE), 32'h2);
    regWriteM = 0; #1;
    chk("fwdA_W", 32'(forwardAE), 32'h1);
    rs1E = 0; regWriteM = 1; #1;
    chk("fwdA_x0", 32'(forwardAE), 32'h0);
    rs2E = 5; rdM = 3; #1;
    chk("fwdB_W", 32'(forwardBE), 32'h1);
    idle_inputs();

    // load-use
    tick();
    resultSrcE0 = 1; rdE = 7; rs2D = 7; #1;
    chk("lu_stallF", 32'(stallF), 1);
    chk("lu_stallD", 32'(stallD), 1);
    chk("lu_flushE", 32'(flushE), 1);
    chk("lu_flushD", 32'(flushD), 0);
    chk("lu_stallE", 32'(stallE), 0);
    rdE = 0; rs2D = 0; #1;
    chk("lu_x0_stallF", 32'(stallF), 0);
    chk("lu_x0_flushE", 32'(flushE), 0);
    idle_inputs();

    // mul/div, MD_LAT=4 and MD_LAT=1
    tick();
    mdStartE = 1; #1;
    chk("md_c1_stallE", 32'(stallE), 1);
    chk("md_c1_flushM", 32'(flushM), 1);
    chk("md_c1_busy", 32'(mdBusy), 0);
    chk("md1_stallF", 32'(stallF_1), 0);
    chk("md1_flushM", 32'(flushM_1), 0);
    tick();
    chk("md_c2_stallE", 32'(stallE), 1);
    chk("md_c2_flushM", 32'(flushM), 1);
    chk("md_c2_busy", 32'(mdBusy), 1);
    chk("md1_busy", 32'(mdBusy_1), 0);
    tick();
    chk("md_c3_stallE", 32'(stallE), 1);
    chk("md_c3_busy", 32'(mdBusy), 1);
    tick();
    chk("md_c4_stallE", 32'(stallE), 0);
    chk("md_c4_flushM", 32'(flushM), 0);
    tick();
    mdStartE = 0; #1;
    chk("md_c5_busy", 32'(mdBusy), 0);

    // memory wait during MD_BUSY at cnt=2
    mdStartE = 1; #1;
    tick();
    tick();
    memReqM = 1; memReadyM = 0; #1;
    chk("mw_c3_stallM", 32'(stallM), 1);
    chk("mw_c3_flushW", 32'(flushW), 1);
    chk("mw_c3_flushM", 32'(flushM), 0);
    chk("mw_c3_stallF", 32'(stallF), 1);
    tick();
    chk("mw_c4_stallM", 32'(stallM), 1);
    chk("mw_c4_busy", 32'(mdBusy), 1);
    tick();
    memReqM = 0; #1;
    chk("mw_c5_stallE", 32'(stallE), 1);
    chk("mw_c5_flushM", 32'(flushM), 1);
    tick();
    chk("mw_c6_stallE", 32'(stallE), 0);
    tick();
    mdStartE = 0; #1;
    chk("mw_c7_busy", 32'(mdBusy), 0);

    // branch deferred behind mul/div
    mdStartE = 1; pcSrcE = 2'b01; #1;
    chk("br_c1_flushD", 32'(flushD), 0);
    chk("br_c1_flushE", 32'(flushE), 0);
    tick();
    chk("br_c2_flushD", 32'(flushD), 0);
    tick();
    tick();
    chk("br_rel_flushD", 32'(flushD), 1);
    chk("br_rel_flushE", 32'(flushE), 1);
    tick();
    idle_inputs(); #1;

    // branch beats load-use
    pcSrcE = 2'b01; resultSrcE0 = 1; rdE = 7; rs1D = 7; #1;
    chk("brlu_stallF", 32'(stallF), 0);
    chk("brlu_flushD", 32'(flushD), 1);
    chk("brlu_flushE", 32'(flushE), 1);
    idle_inputs();

    // stall counter saturation and clear
    clrStats = 1;
    tick();
    clrStats = 0; #1;
    chk("cnt_clr0", 32'(stallCount), 0);
    memReqM = 1; memReadyM = 0;
    repeat (5) tick();
    chk("cnt_5", 32'(stallCount), 5);
    repeat (14) tick();
    chk("cnt_sat", 32'(stallCount), 15);
    clrStats = 1;
    tick();
    chk("cnt_clr", 32'(stallCount), 0);
    idle_inputs();

    // async reset mid-MD_BUSY
    tick();
    mdStartE = 1;
    tick();
    chk("ar_busy", 32'(mdBusy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy_clr", 32'(mdBusy), 0);
    idle_inputs();
    #3;
    rst_n = 1'b1;
    tick();
    chk("ar_post_busy", 32'(mdBusy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
